lcv_mul_acc_arb: RTL
====================

Name: lcv_mul_acc_arb

Overview:
- Round-robin arbiter and sequencer that shares one signed 16x16 multiply-accumulate datapath among NUM_REQ requesters.
- Each requester owns a private ACC_WIDTH-bit accumulator held inside this block.
- Accepts at most one operation per cycle and returns the new accumulator value to the issuing requester after LATENCY cycles.
- Sits between the scalar-op issue logic and the DSP-mapped MAC, so several engines can use one DSP slice.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..8.
- ACC_WIDTH, 33, accumulator and result width (two's complement).
- LATENCY, 1, accept-to-response cycles; legal values 1 or 2 (2 adds a registered product stage).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant; an op is accepted when req_valid[i] and req_ready[i] are both high.
- req_clr  in  NUM_REQ  per-requester: when high, accumulate onto 0 instead of acc[i].
- req_a  in  NUM_REQ*16  signed multiplicands; slice i is bits [16i+15:16i].
- req_b  in  NUM_REQ*16  signed multipliers, packed the same way.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  ACC_WIDTH  new accumulator value of the responding requester.
- busy  out  1  high while any accepted op is still in flight.

Behaviour:
- Reset: rsp_valid=0, rsp_data=0, every acc[i]=0, rr_ptr=0, in-flight pipeline empty, busy=0.
- req_ready is combinational from req_valid and rr_ptr only; it never depends on a, b or clr.
- Arbitration:
  - Grant the first i with req_valid[i] high, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At most one req_ready bit is high; req_ready is all zeros when no request is valid.
- rr_ptr update: on accept, rr_ptr <= (granted index + 1) mod NUM_REQ; otherwise it holds.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles.
- Arithmetic:
  - product = sign-extended a*b (32-bit signed).
  - new = sext(product, ACC_WIDTH) + (clr ? 0 : acc[i]), wrapping modulo 2^ACC_WIDTH.
  - No saturation and no overflow flag.
- LATENCY=1:
  - At the accept edge, acc[i] <= new and rsp_data <= new; rsp_valid[i] is high for the following cycle.
- LATENCY=2:
  - The accept edge registers product, index and clr.
  - The next edge reads acc[index], writes acc[index] <= new, and drives rsp_data/rsp_valid.
- Back-to-back ops from the same requester must chain correctly in both modes with no stall.
  - This holds because the accumulator is read in the final stage; no forwarding path and no bubble are allowed.
- Throughput: one accept per cycle, sustained; there is no response backpressure.
- rsp_valid is one-hot or zero; rsp_data holds its last value when rsp_valid is zero.
- busy = any in-flight stage valid, or rsp_valid pending.
- Inputs a/b/clr are sampled only at the accept edge and may change freely otherwise.
- Reset mid-operation drops in-flight ops:
  - No rsp_valid is issued for them; accumulators return to 0 and rr_ptr returns to 0.
- NUM_REQ=1: always grants requester 0 when it is valid; rr_ptr stays 0.

Decomposition:
- Shared package lcv_mul_acc_pkg holds:
  - MAC_IN_WIDTH=16 and PROD_WIDTH=32.
  - Typedef mac_op_t {index, clr, product}.
  - Function rr_pick(valid, ptr) returning a one-hot grant.
- One sub-module, lcv_rr_arbiter (parameter N), contains the round-robin pick and pointer register.
- The MAC stage(s) and accumulator bank stay in lcv_mul_acc_arb.

Test Plan:
- Reset, then req0 with a=3, b=-4, clr=1 -> rsp_valid=0001 after LATENCY cycles, rsp_data=-12; then req0 with a=2, b=5, clr=0 -> rsp_data=-2.
- All four requesters valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; each response index matches its grant delayed LATENCY cycles.
- Requester 2 issues 4 consecutive ops (a=b=100, first clr=1), run at LATENCY=1 and LATENCY=2 -> responses 10000, 20000, 30000, 40000 with no idle cycles.
- Overflow: repeated a=b=-32768 with clr=0 (product +2^30) -> the 4th result is -2^32, i.e. bits wrap modulo 2^33 with no flag.
- Assert rst while 2 ops are in flight (LATENCY=2) -> no rsp_valid afterwards, busy=0; the next op with clr=0 returns a*b, since accumulators read 0.
- Requesters 1 and 3 valid with rr_ptr=2 -> requester 3 is granted first, then 1; rr_ptr ends at 2.

Source files
------------

// File: rtl/lcv_mul_acc_pkg.sv
// Shared types and helpers for the round-robin multiply-accumulate sequencer.
// Widths are fixed for the largest legal requester count so every user agrees.
package lcv_mul_acc_pkg;

  localparam int MAC_IN_WIDTH = 16;
  localparam int PROD_WIDTH   = 32;
  localparam int MAX_REQ      = 8;
  localparam int IDX_WIDTH    = 3;

  typedef struct packed {
    logic [IDX_WIDTH-1:0]         index;
    logic                         clr;
    logic signed [PROD_WIDTH-1:0] product;
  } mac_op_t;

  // One-hot grant: first valid requester scanning ptr, ptr+1, ... modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [IDX_WIDTH-1:0] ptr,
                                                 input int n);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && valid[idx[IDX_WIDTH-1:0]]) begin
        grant[idx[IDX_WIDTH-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/lcv_rr_arbiter.sv
// Round-robin requester pick plus the rotating priority pointer.
// Any valid request is accepted; there is no downstream backpressure.
module lcv_rr_arbiter
  import lcv_mul_acc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         valid_i,
  output logic [N-1:0]         grant_o,
  output logic [IDX_WIDTH-1:0] grant_idx_o,
  output logic                 fire_o,
  output logic [IDX_WIDTH-1:0] ptr_o
);

  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [MAX_REQ-1:0]   pick;

  always_comb begin
    pick        = rr_pick(MAX_REQ'(valid_i), ptr_q, N);
    grant_o     = pick[N-1:0];
    grant_idx_o = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) grant_idx_o = IDX_WIDTH'(i);
    end
  end

  assign fire_o = |valid_i;
  assign ptr_o  = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (fire_o) begin
      ptr_d = (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lcv_mul_acc_arb.sv
// Shares one signed 16x16 MAC among NUM_REQ requesters, each with a private
// accumulator; the result returns to the issuer LATENCY cycles after accept.
module lcv_mul_acc_arb
  import lcv_mul_acc_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ACC_WIDTH = 33,
  parameter int LATENCY   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_clr,
  input  logic [NUM_REQ*16-1:0]        req_a,
  input  logic [NUM_REQ*16-1:0]        req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [ACC_WIDTH-1:0]         rsp_data,
  output logic                         busy
);

  // Handshake: an op is accepted on a rising edge where req_valid[i] and
  // req_ready[i] are both high; responses carry no ready and cannot stall.

  logic [NUM_REQ-1:0]        grant;
  logic [IDX_WIDTH-1:0]      grant_idx;
  logic [IDX_WIDTH-1:0]      rr_ptr;
  logic                      fire;

  logic signed [MAC_IN_WIDTH-1:0] a_sel, b_sel;
  logic                           clr_sel;
  logic signed [PROD_WIDTH-1:0]   prod;
  mac_op_t                        acc_op;

  mac_op_t                   fin_op;
  logic                      fin_vld;
  logic                      stage_busy;

  logic [ACC_WIDTH-1:0]      acc_q [NUM_REQ];
  logic [ACC_WIDTH-1:0]      acc_rd;
  logic [ACC_WIDTH-1:0]      new_val;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [ACC_WIDTH-1:0]      rsp_data_q;

  lcv_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (req_valid),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .fire_o      (fire),
    .ptr_o       (rr_ptr)
  );

  assign req_ready = grant;

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    clr_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel   = req_a[16*i +: 16];
        b_sel   = req_b[16*i +: 16];
        clr_sel = req_clr[i];
      end
    end
  end

  assign prod = a_sel * b_sel;

  always_comb begin
    acc_op.index   = grant_idx;
    acc_op.clr     = clr_sel;
    acc_op.product = prod;
  end

  // The accumulator is read only in the final stage, so same-requester ops
  // chain back to back without forwarding in either latency mode.
  generate
    if (LATENCY == 2) begin : g_pipe
      mac_op_t op_q;
      logic    op_vld_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          op_q     <= '0;
          op_vld_q <= 1'b0;
        end else begin
          op_vld_q <= fire;
          if (fire) op_q <= acc_op;
        end
      end
      assign fin_op     = op_q;
      assign fin_vld    = op_vld_q;
      assign stage_busy = op_vld_q;
    end else begin : g_direct
      assign fin_op     = acc_op;
      assign fin_vld    = fire;
      assign stage_busy = 1'b0;
    end
  endgenerate

  always_comb begin
    acc_rd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fin_op.index == IDX_WIDTH'(i)) acc_rd = acc_q[i];
    end
  end

  assign new_val = ACC_WIDTH'($signed(fin_op.product)) + (fin_op.clr ? '0 : acc_rd);

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = fin_vld && (fin_op.index == IDX_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) acc_q[i] <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (fin_vld) begin
        rsp_data_q <= new_val;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (rsp_valid_d[i]) acc_q[i] <= new_val;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = stage_busy | (|rsp_valid_q);

  // rr_ptr is observable in simulation for checker binding; it has no port.
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr;

endmodule
